// File: rtl/seg7_pkg.sv
// Shared glyph constants and helpers for the seven-segment scanner.
// All patterns are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Width of a counter that spans 0..prescale-1.
  function automatic int cnt_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with hex/decimal mode and forced blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  input  logic       blank,
  output logic [6:0] seg
);

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (hex_en || (nibble < 4'd10))) begin
      seg = glyph(nibble);
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode display driver: shadow registers, prescaler,
// digit index, leading-zero blanking and registered active-low pin outputs.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  hex_en,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int              PW     = cnt_width(PRESCALE);
  localparam int              IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]   P_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]   I_LAST = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] val_q;
  logic [DIGITS-1:0]   dp_q;
  logic                hex_q;
  logic                lz_q;

  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic                tc;
  logic                frame_end;

  logic [DIGITS-1:0]   nib_zero;
  logic [DIGITS-1:0]   zero_from;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_zero_from;
  logic                lz_hit;
  logic [DIGITS-1:0]   an_d;
  logic [6:0]          seg_d;

  // NOTE: the shadow is a few flops rather than a RAM, so it is reset to show a defined zero value.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      dp_q  <= '0;
      hex_q <= 1'b0;
      lz_q  <= 1'b0;
    end else if (load) begin
      val_q <= value;
      dp_q  <= dp_in;
      hex_q <= hex_en;
      lz_q  <= lz_blank;
    end
  end

  assign tc        = (pcnt == P_LAST);
  assign frame_end = tc && (idx == I_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tc) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (tc) begin
      idx <= (idx == I_LAST) ? '0 : idx + IW'(1);
    end
  end

  // zero_from[i] is set when digit i and every digit above it are zero.
  always_comb begin
    nib_zero  = '0;
    zero_from = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib_zero[i] = (val_q[4*i +: 4] == 4'd0);
    end
    zero_from[DIGITS-1] = nib_zero[DIGITS-1];
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = nib_zero[i] && zero_from[i+1];
    end
  end

  always_comb begin
    cur_nib       = 4'd0;
    cur_dp        = 1'b0;
    cur_zero_from = 1'b0;
    an_d          = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib       = val_q[4*i +: 4];
        cur_dp        = dp_q[i];
        cur_zero_from = zero_from[i];
        an_d[i]       = 1'b0;
      end
    end
  end

  // Digit 0 is never suppressed so an all-zero value still shows "0".
  assign lz_hit = lz_q && (idx != '0) && cur_zero_from;

  seg7_decode u_decode (
    .nibble (cur_nib),
    .hex_en (hex_q),
    .blank  (lz_hit),
    .seg    (seg_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      dp         <= ~cur_dp;
      an         <= an_d;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: a cycle-count reference model queues expected pins each edge,
// a negedge monitor pops and compares them against the scanner outputs.
module tb_seven_segment_scanner;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int FRAME    = DIGITS * PRESCALE;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        load     = 1'b0;
  logic [15:0] value    = '0;
  logic [3:0]  dp_in    = '0;
  logic        hex_en   = 1'b0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seven_segment_scanner #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .hex_en     (hex_en),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } pins_t;

  pins_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model state: what the display has latched, and edges seen since reset.
  logic [15:0] m_val   = '0;
  logic [3:0]  m_dp    = '0;
  logic        m_hex   = 1'b0;
  logic        m_lz    = 1'b0;
  int          m_edges = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int d,
                                         input logic hx, input logic lz);
    logic [15:0] hi;
    int          nib;
    hi  = v >> (4 * d);
    nib = int'(hi[3:0]);
    if (lz && d != 0 && hi == 16'h0) return 7'h7f;
    if (!hx && nib >= 10) return 7'h7f;
    return glyph_tab[nib];
  endfunction

  // After edge n the pins show digit ((n-1)/PRESCALE) mod DIGITS of the data
  // latched before edge n; frame_done follows every FRAME-th edge.
  always @(posedge clk or posedge rst) begin
    int    n;
    int    d;
    pins_t e;
    if (rst) begin
      exp_q.delete();
      m_val   <= '0;
      m_dp    <= '0;
      m_hex   <= 1'b0;
      m_lz    <= 1'b0;
      m_edges <= 0;
    end else begin
      n     = m_edges + 1;
      d     = ((n - 1) / PRESCALE) % DIGITS;
      e.an  = ~(4'b0001 << d);
      e.seg = ref_seg(m_val, d, m_hex, m_lz);
      e.dp  = ~m_dp[d];
      e.fd  = (n % FRAME == 0);
      exp_q.push_back(e);
      m_edges <= n;
      if (load) begin
        m_val <= value;
        m_dp  <= dp_in;
        m_hex <= hex_en;
        m_lz  <= lz_blank;
      end
    end
  end

  always @(negedge clk) begin
    pins_t e;
    if (rst) begin
      check("reset_pins", {19'd0, an, seg, dp, frame_done}, {19'd0, 4'hf, 7'h7f, 1'b1, 1'b0});
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("an",         {28'd0, an},         {28'd0, e.an});
      check("seg",        {25'd0, seg},        {25'd0, e.seg});
      check("dp",         {31'd0, dp},         {31'd0, e.dp});
      check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
    end
  end

  task automatic scramble_live();
    value    = 16'($urandom);
    dp_in    = 4'($urandom);
    hex_en   = 1'($urandom);
    lz_blank = 1'($urandom);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpi,
                         input logic hx, input logic lz);
    @(negedge clk);
    load = 1'b1; value = v; dp_in = dpi; hex_en = hx; lz_blank = lz;
    @(negedge clk);
    load = 1'b0;
    scramble_live();
  endtask

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    logic [15:0] rv;

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    run(FRAME + 2);

    // Decimal digits with no blanking.
    do_load(16'h1234, 4'b0000, 1'b0, 1'b0);
    run(2 * FRAME);

    // Hex letters, then the same nibbles in decimal mode (all blank).
    do_load(16'hABCF, 4'b0000, 1'b1, 1'b0);
    run(2 * FRAME);
    do_load(16'hABCF, 4'b0000, 1'b0, 1'b0);
    run(FRAME);

    // Leading-zero blanking with a decimal point on a blanked digit.
    do_load(16'h0050, 4'b0100, 1'b0, 1'b1);
    run(FRAME);
    do_load(16'h0000, 4'b0000, 1'b0, 1'b1);
    run(FRAME);

    // Load coinciding with a digit advance edge.
    found = 1'b0;
    for (int i = 0; i < 2 * PRESCALE; i++) begin
      @(negedge clk);
      if ((m_edges + 1) % PRESCALE == 0) begin
        found = 1'b1;
        break;
      end
    end
    check("advance_edge_found", {31'd0, found}, 32'd1);
    load = 1'b1; value = 16'h9999; dp_in = 4'b0000; hex_en = 1'b0; lz_blank = 1'b0;
    @(negedge clk);
    load = 1'b0;
    scramble_live();
    run(FRAME);

    // Randomized loads at random times, with varied leading-zero depth.
    for (int k = 0; k < 40; k++) begin
      rv = 16'($urandom) >> $urandom_range(0, 16);
      do_load(rv, 4'($urandom), 1'($urandom), 1'($urandom));
      run($urandom_range(0, 20));
    end
    run(FRAME);

    // Asynchronous reset in the middle of digit 2's slot.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if ((((m_edges - 1) / PRESCALE) % DIGITS == 2) && ((m_edges - 1) % PRESCALE == 1)) begin
        found = 1'b1;
        break;
      end
    end
    check("digit2_found", {31'd0, found}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_an",  {28'd0, an},         32'hf);
    check("async_rst_seg", {25'd0, seg},        32'h7f);
    check("async_rst_dp",  {31'd0, dp},         32'd1);
    check("async_rst_fd",  {31'd0, frame_done}, 32'd0);
    run(2);
    #1 rst = 1'b0;
    run(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
